// File: rtl/ysyx_idu_pkg.sv
// ysyx_idu_pkg: shared constants and types for the RV32I decode stage.
// Optional feature macro: YSYX_IDU_RV32M_EN (RV32M multiply/divide decode).
package ysyx_idu_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    // ALU operation encodings
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd14;
    localparam logic [4:0] ALU_MUL    = 5'd16; // MUL..REMU occupy 16..23 in funct3 order

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_PC4 = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    // Data-memory read select
    localparam logic [2:0] DM_RD_NONE = 3'd0;
    localparam logic [2:0] DM_RD_LB   = 3'd1;
    localparam logic [2:0] DM_RD_LBU  = 3'd2;
    localparam logic [2:0] DM_RD_LH   = 3'd3;
    localparam logic [2:0] DM_RD_LHU  = 3'd4;
    localparam logic [2:0] DM_RD_LW   = 3'd5;

    // Data-memory write select
    localparam logic [1:0] DM_WR_NONE = 2'd0;
    localparam logic [1:0] DM_WR_SB   = 2'd1;
    localparam logic [1:0] DM_WR_SH   = 2'd2;
    localparam logic [1:0] DM_WR_SW   = 2'd3;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HALT  = 2'd2
    } idu_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [4:0]  alu_ctrl;
        logic        alu_a_sel;
        logic        alu_b_sel;
        logic        rf_wr_en;
        logic [1:0]  rf_wr_sel;
        logic        jump;
        logic        branch;
        logic [2:0]  br_func;
        logic [2:0]  dm_rd_sel;
        logic [1:0]  dm_wr_sel;
        logic        ebreak;
        logic        illegal;
    } idu_bundle_t;

    // Map funct3 (plus the inst[30] alternate bit) onto an integer ALU op
    function automatic logic [4:0] alu_op_f3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_idu_stage_imm_gen.sv
// ysyx_imm_gen: combinational immediate extender for the I/S/B/U/J formats.
// Only inst[31:7] carries immediate bits, so the opcode field is not an input.
module ysyx_imm_gen
    import ysyx_idu_pkg::*;
(
    input  logic [31:7] inst,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    // Select and sign-extend the immediate for the requested format
    always_comb begin
        imm = 32'h0000_0000;
        case (imm_type)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'h000};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ysyx_idu_stage.sv
// ysyx_idu_stage: registered RV32I decode stage with valid/ready on both sides,
// flush, sticky halt after ebreak leaves the stage, and a handed-down counter.
// Optional feature macro: YSYX_IDU_RV32M_EN (decode RV32M into ALU MUL..REMU).
module ysyx_idu_stage
    import ysyx_idu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           inst,
    input  logic [XLEN-1:0]       pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [31:0]           imm,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_a_sel,
    output logic                  alu_b_sel,
    output logic                  rf_wr_en,
    output logic [1:0]            rf_wr_sel,
    output logic                  jump,
    output logic                  branch,
    output logic [2:0]            br_func,
    output logic [2:0]            dm_rd_sel,
    output logic [1:0]            dm_wr_sel,
    output logic                  ebreak,
    output logic                  illegal,
    output logic                  halted,
    output logic [CNT_W-1:0]      decode_cnt
);

    idu_state_e        state_r, state_nxt_s;
    idu_bundle_t       bundle_r, dec_s;
    logic [XLEN-1:0]   pc_r;
    logic [CNT_W-1:0]  cnt_r;
    imm_type_e         imm_type_s;
    logic [31:0]       imm_s;
    logic              illegal_s;
    logic              in_fire_s, out_fire_s, load_s;
    logic [2:0]        f3_s;
    logic [6:0]        f7_s;

    assign f3_s = inst[14:12];
    assign f7_s = inst[31:25];

    ysyx_imm_gen u_imm_gen (
        .inst     (inst[31:7]),
        .imm_type (imm_type_s),
        .imm      (imm_s)
    );

    // Full decode of the incoming instruction word into a control bundle
    always_comb begin
        dec_s          = '0;
        dec_s.rs1      = inst[19:15];
        dec_s.rs2      = inst[24:20];
        dec_s.alu_ctrl = ALU_ADD;
        imm_type_s     = IMM_I;
        illegal_s      = 1'b0;
        case (inst[6:0])
            OPC_LUI: begin
                imm_type_s = IMM_U; dec_s.alu_ctrl = ALU_PASS_B;
                dec_s.alu_b_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type_s = IMM_U; dec_s.alu_b_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
            end
            OPC_JAL: begin
                imm_type_s = IMM_J; dec_s.alu_b_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
                dec_s.rf_wr_sel = WB_PC4; dec_s.jump = 1'b1;
            end
            OPC_JALR: begin
                dec_s.alu_a_sel = 1'b1; dec_s.alu_b_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
                dec_s.rf_wr_sel = WB_PC4; dec_s.jump = 1'b1;
                illegal_s = (f3_s != 3'b000);
            end
            OPC_BRANCH: begin
                imm_type_s = IMM_B; dec_s.alu_a_sel = 1'b1; dec_s.alu_ctrl = ALU_SUB;
                dec_s.branch = 1'b1; dec_s.br_func = f3_s;
                illegal_s = (f3_s == 3'b010) || (f3_s == 3'b011);
            end
            OPC_LOAD: begin
                dec_s.alu_a_sel = 1'b1; dec_s.alu_b_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
                dec_s.rf_wr_sel = WB_MEM;
                case (f3_s)
                    3'b000:  dec_s.dm_rd_sel = DM_RD_LB;
                    3'b001:  dec_s.dm_rd_sel = DM_RD_LH;
                    3'b010:  dec_s.dm_rd_sel = DM_RD_LW;
                    3'b100:  dec_s.dm_rd_sel = DM_RD_LBU;
                    3'b101:  dec_s.dm_rd_sel = DM_RD_LHU;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                imm_type_s = IMM_S; dec_s.alu_a_sel = 1'b1; dec_s.alu_b_sel = 1'b1;
                case (f3_s)
                    3'b000:  dec_s.dm_wr_sel = DM_WR_SB;
                    3'b001:  dec_s.dm_wr_sel = DM_WR_SH;
                    3'b010:  dec_s.dm_wr_sel = DM_WR_SW;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_s.alu_a_sel = 1'b1; dec_s.alu_b_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
                // Shift-immediates carry a funct7; srai is told apart by inst[30]
                if ((f3_s == 3'b001) && (f7_s != 7'b0000000)) begin
                    illegal_s = 1'b1;
                end else if ((f3_s == 3'b101) && (f7_s != 7'b0000000) && (f7_s != 7'b0100000)) begin
                    illegal_s = 1'b1;
                end else begin
                    dec_s.alu_ctrl = alu_op_f3(f3_s, (f3_s == 3'b101) && inst[30]);
                end
            end
            OPC_OP: begin
                dec_s.alu_a_sel = 1'b1; dec_s.rf_wr_en = 1'b1;
                if (f7_s == 7'b0000000) begin
                    dec_s.alu_ctrl = alu_op_f3(f3_s, 1'b0);
                end else if ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101))) begin
                    dec_s.alu_ctrl = alu_op_f3(f3_s, 1'b1);
                end else if (f7_s == 7'b0000001) begin
`ifdef YSYX_IDU_RV32M_EN
                    dec_s.alu_ctrl = ALU_MUL | {2'b00, f3_s};
`else
                    illegal_s = 1'b1;
`endif
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_FENCE: begin
                illegal_s = (f3_s != 3'b000);
            end
            OPC_SYSTEM: begin
                if (inst == INST_EBREAK) begin
                    dec_s.ebreak = 1'b1;
                end else if (inst == INST_ECALL) begin
                    dec_s.ebreak = 1'b0;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: illegal_s = 1'b1;
        endcase
        // An illegal op must not cause any architectural side effect downstream
        dec_s.illegal   = illegal_s;
        dec_s.rf_wr_en  = dec_s.rf_wr_en & ~illegal_s;
        dec_s.dm_wr_sel = illegal_s ? DM_WR_NONE : dec_s.dm_wr_sel;
        dec_s.jump      = dec_s.jump & ~illegal_s;
        dec_s.branch    = dec_s.branch & ~illegal_s;
        dec_s.rd        = dec_s.rf_wr_en ? inst[11:7] : 5'd0;
        dec_s.imm       = imm_s;
    end

    assign halted     = (state_r == ST_HALT);
    assign out_valid  = (state_r == ST_FULL);
    assign in_ready   = !halted && ((state_r == ST_EMPTY) || out_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;
    assign load_s     = in_fire_s && !flush;

    // Next-state logic: flush wins, then ebreak leaving halts, then fill/drain
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (flush)          state_nxt_s = ST_EMPTY;
                else if (in_fire_s) state_nxt_s = ST_FULL;
                else                state_nxt_s = ST_EMPTY;
            end
            ST_FULL: begin
                if (flush)                             state_nxt_s = ST_EMPTY;
                else if (out_fire_s && bundle_r.ebreak) state_nxt_s = ST_HALT;
                else if (in_fire_s)                    state_nxt_s = ST_FULL;
                else if (out_fire_s)                   state_nxt_s = ST_EMPTY;
                else                                   state_nxt_s = ST_FULL;
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_EMPTY;
        else        state_r <= state_nxt_s;
    end

    // Bundle register: captured only on an accepted, non-flushed input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_r <= '0;
            pc_r     <= '0;
        end else if (load_s) begin
            bundle_r <= dec_s;
            pc_r     <= pc;
        end
    end

    // Count every bundle handed downstream, including one leaving under flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt_r <= '0;
        else if (out_fire_s) cnt_r <= cnt_r + CNT_W'(1'b1);
    end

    assign out_pc     = pc_r;
    assign rd         = bundle_r.rd;
    assign rs1        = bundle_r.rs1;
    assign rs2        = bundle_r.rs2;
    assign imm        = bundle_r.imm;
    assign alu_ctrl   = ALU_CTRL_W'(bundle_r.alu_ctrl);
    assign alu_a_sel  = bundle_r.alu_a_sel;
    assign alu_b_sel  = bundle_r.alu_b_sel;
    assign rf_wr_en   = bundle_r.rf_wr_en;
    assign rf_wr_sel  = bundle_r.rf_wr_sel;
    assign jump       = bundle_r.jump;
    assign branch     = bundle_r.branch;
    assign br_func    = bundle_r.br_func;
    assign dm_rd_sel  = bundle_r.dm_rd_sel;
    assign dm_wr_sel  = bundle_r.dm_wr_sel;
    assign ebreak     = bundle_r.ebreak;
    assign illegal    = bundle_r.illegal;
    assign decode_cnt = cnt_r;

endmodule

// File: tb/tb_ysyx_idu_stage.sv
// Directed bench for ysyx_idu_stage; expectations are hand-decoded constants.
// Honours YSYX_IDU_RV32M_EN for the mul vector.
module tb_ysyx_idu_stage;

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst, pc, out_pc, imm, decode_cnt;
    logic [4:0]  rd, rs1, rs2, alu_ctrl;
    logic        alu_a_sel, alu_b_sel, rf_wr_en, jump, branch, ebreak, illegal, halted;
    logic [1:0]  rf_wr_sel, dm_wr_sel;
    logic [2:0]  br_func, dm_rd_sel;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_exp = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  alu;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  wsel;
        logic [2:0]  drd;
        logic        br;
        logic        ill;
    } vec_t;
    vec_t vecs[8];

    ysyx_idu_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_ctrl(alu_ctrl),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_wr_en(rf_wr_en),
        .rf_wr_sel(rf_wr_sel), .jump(jump), .branch(branch), .br_func(br_func),
        .dm_rd_sel(dm_rd_sel), .dm_wr_sel(dm_wr_sel), .ebreak(ebreak),
        .illegal(illegal), .halted(halted), .decode_cnt(decode_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'hFFF0_0093, 32'hFFFF_FFFF, 1'b1, 5'd0,  5'd1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // addi x1,x0,-1
        vecs[1] = '{32'h0020_9463, 32'h0000_0008, 1'b1, 5'd1,  5'd0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0}; // bne x1,x2,8
        vecs[2] = '{32'h4033_5293, 32'h0000_0403, 1'b1, 5'd7,  5'd5, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // srai x5,x6,3
        vecs[3] = '{32'h1234_53B7, 32'h1234_5000, 1'b1, 5'd14, 5'd7, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // lui x7
        vecs[4] = '{32'h0040_D203, 32'h0000_0004, 1'b1, 5'd0,  5'd4, 1'b1, 2'd2, 3'd4, 1'b0, 1'b0}; // lhu x4,4(x1)
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 5'd0,  5'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1}; // illegal
        vecs[6] = '{32'h4020_81B3, 32'h0000_0000, 1'b0, 5'd1,  5'd3, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0}; // sub x3,x1,x2
        vecs[7] = '{32'h0000_0073, 32'h0000_0000, 1'b0, 5'd0,  5'd0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0}; // ecall

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        inst = 32'h0000_0013; pc = 32'h8000_0000;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt", decode_cnt, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_alu", {27'd0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // addi x1,x0,5 straight through
        inst = 32'h0050_0093; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_rd", {27'd0, rd}, 32'd1);
        chk("addi_rs1", {27'd0, rs1}, 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_alu", {27'd0, alu_ctrl}, 32'd0);
        chk("addi_sels", {29'd0, alu_a_sel, alu_b_sel, rf_wr_en}, 32'd7);
        chk("addi_pc", out_pc, 32'h8000_0000);
        tick();
        cnt_exp = 1;
        chk("addi_cnt", decode_cnt, cnt_exp);
        chk("addi_drain", {31'd0, out_valid}, 32'd0);

        // sw x2,8(x1) held under back-pressure
        inst = 32'h0020_A423; pc = 32'h8000_0004; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; inst = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            chk("sw_valid", {31'd0, out_valid}, 32'd1);
            chk("sw_in_ready", {31'd0, in_ready}, 32'd0);
            chk("sw_dm_wr", {30'd0, dm_wr_sel}, 32'd3);
            chk("sw_imm", imm, 32'd8);
            chk("sw_rd_wr", {26'd0, rd, rf_wr_en}, 32'd0);
            chk("sw_rs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
            chk("sw_cnt_hold", decode_cnt, cnt_exp);
            if (c < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        cnt_exp = 2;
        chk("sw_cnt", decode_cnt, cnt_exp);

        // jal x1,16 then flush while stalled
        inst = 32'h0100_00EF; pc = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("jal_ctrl", {26'd0, jump, rf_wr_sel, alu_a_sel, alu_b_sel, rf_wr_en}, {26'd0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1});
        chk("jal_imm", imm, 32'd16);
        chk("jal_rd", {27'd0, rd}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_cnt", decode_cnt, cnt_exp);

        // input arriving together with flush is discarded
        inst = 32'h0050_0093; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_drop", {31'd0, out_valid}, 32'd0);

        // eight back-to-back addi xi,x0,i
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inst = {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011};
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            tick();
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_rd", {27'd0, rd}, i);
            chk("b2b_cnt", decode_cnt, cnt_exp + i - 1);
        end
        in_valid = 1'b0;
        tick();
        cnt_exp = 10;
        chk("b2b_total", decode_cnt, cnt_exp);

        // decode table, streamed at full rate
        for (int i = 0; i < 8; i++) begin
            inst = vecs[i].ins; in_valid = 1'b1;
            tick();
            chk("tbl_alu", {27'd0, alu_ctrl}, {27'd0, vecs[i].alu});
            chk("tbl_rd", {27'd0, rd}, {27'd0, vecs[i].rd});
            chk("tbl_wr", {26'd0, rf_wr_en, rf_wr_sel, dm_rd_sel}, {26'd0, vecs[i].wr, vecs[i].wsel, vecs[i].drd});
            chk("tbl_br", {30'd0, branch, illegal}, {30'd0, vecs[i].br, vecs[i].ill});
            chk("tbl_side", {28'd0, jump, dm_wr_sel, ebreak}, 32'd0);
            if (vecs[i].chk_imm) chk("tbl_imm", imm, vecs[i].imm);
            if (vecs[i].br) chk("tbl_br_func", {29'd0, br_func}, 32'd1);
        end

        // mul x3,x1,x2
        inst = 32'h0220_81B3;
        tick();
        in_valid = 1'b0;
`ifdef YSYX_IDU_RV32M_EN
        chk("mul_alu", {27'd0, alu_ctrl}, 32'd16);
        chk("mul_ill", {30'd0, illegal, rf_wr_en}, 32'd1);
`else
        chk("mul_ill", {30'd0, illegal, rf_wr_en}, 32'd2);
`endif
        tick();
        cnt_exp = 19;
        chk("tbl_cnt", decode_cnt, cnt_exp);

        // ebreak leaves the stage and halts it
        inst = 32'h0010_0073; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("ebk_held", {29'd0, out_valid, ebreak, halted}, 32'd6);
        out_ready = 1'b1;
        tick();
        cnt_exp = 20;
        chk("ebk_halt", {29'd0, halted, out_valid, in_ready}, 32'd4);
        chk("ebk_cnt", decode_cnt, cnt_exp);
        flush = 1'b1; in_valid = 1'b1; inst = 32'h0050_0093;
        tick();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("halt_flush", {29'd0, halted, out_valid, in_ready}, 32'd4);
        chk("halt_cnt", decode_cnt, cnt_exp);

        // async reset mid-stall
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("unhalt", {31'd0, halted}, 32'd0);
        inst = 32'h0020_A423; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_cnt", decode_cnt, 32'd0);
        chk("arst_imm", imm, 32'd0);
        chk("arst_bits", {20'd0, dm_wr_sel, rs1, rs2}, 32'd0);
        chk("arst_halt", {31'd0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
